// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU operand/result bus for alu_issue_ctrl.
// The master side is the issue controller; the slave side is fetch plus the ALU.
interface alu_issue_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_opext;
    logic        alu_cin;
    logic [15:0] alu_s;
    logic [4:0]  alu_clfzn;

    modport master (
        input  instr, instr_valid, alu_s, alu_clfzn,
        output instr_ready, alu_a, alu_b, alu_opcode, alu_opext, alu_cin
    );

    modport slave (
        output instr, instr_valid, alu_s, alu_clfzn,
        input  instr_ready, alu_a, alu_b, alu_opcode, alu_opext, alu_cin
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit ALU: decodes one instruction per 4 cycles,
// reads operands from a 16x16 register file, drives the ALU and writes back S/flags.
module alu_issue_ctrl #(
    parameter int unsigned REGS = 16
) (
    input  logic                clk,
    input  logic                reset,
    alu_issue_ctrl_if.master    bus,
    output logic [4:0]          psr,
    output logic                done,
    output logic                illegal,
    input  logic [3:0]          dbg_addr,
    output logic [15:0]         dbg_data
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] instr_q;
    logic [15:0] regs [REGS];
    logic [15:0] res_s;
    logic [4:0]  res_f;

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ext;
    logic [3:0]  rs;
    logic        legal;
    logic [15:0] b_nx;
    logic [3:0]  opext_nx;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:8];
    assign ext = instr_q[7:4];
    assign rs  = instr_q[3:0];

    assign bus.alu_cin = psr[4];

    always_comb begin
        legal = 1'b0;
        case (op)
            4'b0000: legal = (ext == 4'b0001) || (ext == 4'b0101) ||
                             (ext == 4'b0110) || (ext == 4'b0111);
            4'b1010: legal = (ext == 4'b0101) || (ext == 4'b0110);
            4'b0101, 4'b0110, 4'b0111: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Immediate forms replace operand B and force the opcode extension to zero.
    always_comb begin
        b_nx     = regs[rs];
        opext_nx = ext;
        case (op)
            4'b0101, 4'b0111: begin
                b_nx     = {{8{instr_q[7]}}, instr_q[7:0]};
                opext_nx = '0;
            end
            4'b0110: begin
                b_nx     = {8'h00, instr_q[7:0]};
                opext_nx = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        bus.instr_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nx = READ;
                end
            end
            READ:    state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // done/illegal are registered on the EXEC->WB edge so they are high exactly in WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q        <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_opcode <= '0;
            bus.alu_opext  <= '0;
            res_s          <= '0;
            res_f          <= '0;
            psr            <= '0;
            done           <= 1'b0;
            illegal        <= 1'b0;
            dbg_data       <= '0;
            for (int unsigned i = 0; i < REGS; i++) begin
                regs[4'(i)] <= '0;
            end
        end else begin
            done     <= 1'b0;
            illegal  <= 1'b0;
            dbg_data <= regs[dbg_addr];
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                    end
                end
                READ: begin
                    bus.alu_a      <= regs[rd];
                    bus.alu_b      <= b_nx;
                    bus.alu_opcode <= op;
                    bus.alu_opext  <= opext_nx;
                end
                EXEC: begin
                    res_s   <= bus.alu_s;
                    res_f   <= bus.alu_clfzn;
                    done    <= 1'b1;
                    illegal <= !legal;
                end
                WB: begin
                    if (legal) begin
                        regs[rd] <= res_s;
                        psr      <= res_f;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stand-in, directed test-plan cases,
// reset abort, randomized instructions against a reference model, back-to-back issue.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;

    int total = 0;
    int bad = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.REGS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .psr      (psr),
        .done     (done),
        .illegal  (illegal),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // ALU behaviour: adds/subs set C (carry/borrow) and F (signed overflow); L, Z, N stay 0.
    // Unsupported codes return a scrambled result with nonzero flags.
    function automatic logic [20:0] alu_fn(input logic [3:0] opc, input logic [3:0] ox,
                                           input logic [15:0] a, input logic [15:0] b,
                                           input logic cin);
        int ia, ib, ic, sa, sb, ur, sr;
        logic is_add, is_sub, use_c;
        ia = a;
        ib = b;
        ic = cin ? 1 : 0;
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        is_add = (opc == 4'h0 && ox inside {4'h5, 4'h6, 4'h7}) || opc inside {4'h5, 4'h6, 4'h7};
        is_sub = (opc == 4'hA && ox inside {4'h5, 4'h6});
        use_c  = (opc == 4'h0 && ox == 4'h7) || opc == 4'h7 || (opc == 4'hA && ox == 4'h6);
        if (!use_c) ic = 0;
        if (is_add) begin
            ur = ia + ib + ic;
            sr = sa + sb + ic;
            return {ur > 65535, 1'b0, (sr > 32767 || sr < -32768), 2'b00, 16'(ur)};
        end
        if (is_sub) begin
            ur = ia - ib - ic;
            sr = sa - sb - ic;
            return {ur < 0, 1'b0, (sr > 32767 || sr < -32768), 2'b00, 16'(ur)};
        end
        if (opc == 4'h0 && ox == 4'h1) return {5'b00000, a & b};
        return {5'b10101, a ^ b ^ 16'h5A5A};
    endfunction

    assign {bus.alu_clfzn, bus.alu_s} = alu_fn(bus.alu_opcode, bus.alu_opext, bus.alu_a,
                                               bus.alu_b, bus.alu_cin);

    // Reference architectural state
    logic [15:0] mr [16];
    logic [4:0]  mpsr;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mr[i] = '0;
        mpsr = '0;
    endfunction

    function automatic void ref_exec(input logic [15:0] ins, output logic lg,
                                     output logic [15:0] ea, output logic [15:0] eb,
                                     output logic [3:0] eext, output logic ecin);
        logic [3:0] op, rd, ext, rs;
        logic [7:0] imm;
        logic [20:0] r;
        op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0]; imm = ins[7:0];
        lg = (op == 4'h0 && ext inside {4'h1, 4'h5, 4'h6, 4'h7}) ||
             (op == 4'hA && ext inside {4'h5, 4'h6}) || op inside {4'h5, 4'h6, 4'h7};
        ea = mr[rd];
        if (op inside {4'h5, 4'h7}) eb = {8'h00, imm} + ((imm >= 8'd128) ? 16'hFF00 : 16'h0000);
        else if (op == 4'h6) eb = {8'h00, imm};
        else eb = mr[rs];
        eext = (op inside {4'h5, 4'h6, 4'h7}) ? 4'h0 : ext;
        ecin = mpsr[4];
        if (lg) begin
            r = alu_fn(op, eext, ea, eb, ecin);
            mr[rd] = r[15:0];
            mpsr = r[20:16];
        end
    endfunction

    // Observations from the most recent issued instruction
    logic        obs_timeout;
    int          obs_ready_low, obs_done_cnt, obs_done_k;
    logic        obs_illegal;
    logic [15:0] obs_a, obs_b, obs_dbg;
    logic [3:0]  obs_opc, obs_ext;
    logic        obs_cin;

    // Drives one instruction and records per-cycle observations; k counts cycles after accept.
    task automatic run_instr(input logic [15:0] ins);
        int w;
        @(negedge clk);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        w = 0;
        while (!bus.instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        obs_timeout = !bus.instr_ready;
        obs_ready_low = 0; obs_done_cnt = 0; obs_done_k = 0; obs_illegal = 1'bx;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            if (!bus.instr_ready) obs_ready_low++;
            if (done) begin
                obs_done_cnt++;
                obs_done_k = k;
                obs_illegal = illegal;
            end
            if (k == 2) begin
                obs_a = bus.alu_a; obs_b = bus.alu_b; obs_opc = bus.alu_opcode;
                obs_ext = bus.alu_opext; obs_cin = bus.alu_cin;
            end
            if (k == 4) obs_dbg = dbg_data;
        end
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        dbg_addr = a;
        @(negedge clk);
        d = dbg_data;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b1; bus.instr_valid = 1'b0; bus.instr = '0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.instr_ready); end
        total++; if (done !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL rst_done got=%b%b exp=00", done, illegal); end
        total++; if (psr !== 5'b0) begin bad++; $display("FAIL rst_psr got=%b exp=00000", psr); end
        total++; if ({bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_opext} !== 40'h0) begin
            bad++; $display("FAIL rst_alu got=%h %h %h %h exp=0", bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_opext); end
        total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL rst_dbg got=%h exp=0000", dbg_data); end
        read_reg(4'd15, d);
        total++; if (d !== 16'h0) begin bad++; $display("FAIL rst_r15 got=%h exp=0000", d); end
        model_reset();
    endtask

    task automatic test_immediate();
        logic [15:0] d;
        dbg_addr = 4'd1;
        run_instr(16'h5105);
        total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL addi_accept got=timeout exp=accept"); end
        total++; if (obs_ready_low !== 3) begin bad++; $display("FAIL addi_ready_low got=%0d exp=3", obs_ready_low); end
        total++; if (obs_done_k !== 3 || obs_done_cnt !== 1) begin
            bad++; $display("FAIL addi_done got=k%0d n%0d exp=k3 n1", obs_done_k, obs_done_cnt); end
        total++; if (obs_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%b exp=0", obs_illegal); end
        total++; if (obs_dbg !== 16'h0000) begin bad++; $display("FAIL dbg_same_cycle got=%h exp=0000", obs_dbg); end
        read_reg(4'd1, d);
        total++; if (d !== 16'h0005) begin bad++; $display("FAIL addi_r1 got=%h exp=0005", d); end
        total++; if (psr !== 5'b00000) begin bad++; $display("FAIL addi_psr got=%b exp=00000", psr); end
        run_instr(16'h62FF);
        total++; if (obs_b !== 16'h00FF || obs_ext !== 4'h0) begin
            bad++; $display("FAIL addui_b got=%h/%h exp=00ff/0", obs_b, obs_ext); end
        run_instr(16'h53FF);
        total++; if (obs_b !== 16'hFFFF) begin bad++; $display("FAIL addi_sext_b got=%h exp=ffff", obs_b); end
        read_reg(4'd2, d);
        total++; if (d !== 16'h00FF) begin bad++; $display("FAIL addui_r2 got=%h exp=00ff", d); end
        read_reg(4'd3, d);
        total++; if (d !== 16'hFFFF) begin bad++; $display("FAIL addi_r3 got=%h exp=ffff", d); end
    endtask

    task automatic test_rtype_carry();
        logic [15:0] d;
        run_instr(16'h0361);
        total++; if (obs_a !== 16'hFFFF || obs_b !== 16'h0005 || obs_ext !== 4'h6) begin
            bad++; $display("FAIL addu_ops got=%h %h %h exp=ffff 0005 6", obs_a, obs_b, obs_ext); end
        read_reg(4'd3, d);
        total++; if (d !== 16'h0004) begin bad++; $display("FAIL addu_r3 got=%h exp=0004", d); end
        total++; if (psr[4] !== 1'b1 || psr[1] !== 1'b0) begin bad++; $display("FAIL addu_psr got=%b exp=1xx0x", psr); end
        run_instr(16'h0271);
        total++; if (obs_cin !== 1'b1) begin bad++; $display("FAIL addc_cin got=%b exp=1", obs_cin); end
        read_reg(4'd2, d);
        total++; if (d !== 16'h0105) begin bad++; $display("FAIL addc_r2 got=%h exp=0105", d); end
        total++; if (psr !== 5'b00000) begin bad++; $display("FAIL addc_psr got=%b exp=00000", psr); end
    endtask

    task automatic test_illegal();
        logic [15:0] d;
        run_instr(16'hF123);
        total++; if (obs_done_cnt !== 1 || obs_illegal !== 1'b1) begin
            bad++; $display("FAIL illegal_flag got=n%0d ill=%b exp=n1 ill=1", obs_done_cnt, obs_illegal); end
        read_reg(4'd1, d);
        total++; if (d !== 16'h0005) begin bad++; $display("FAIL illegal_r1 got=%h exp=0005", d); end
        total++; if (psr !== 5'b00000) begin bad++; $display("FAIL illegal_psr got=%b exp=00000", psr); end
        run_instr(16'h0011);
        total++; if (obs_timeout !== 1'b0 || obs_illegal !== 1'b0) begin
            bad++; $display("FAIL and_after_illegal got=to%b ill=%b exp=to0 ill=0", obs_timeout, obs_illegal); end
        read_reg(4'd0, d);
        total++; if (d !== 16'h0000 || psr !== 5'b0) begin bad++; $display("FAIL and_r0 got=%h/%b exp=0000/00000", d, psr); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] d;
        int dn;
        @(negedge clk);
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL abort_pre_ready got=%b exp=1", bus.instr_ready); end
        bus.instr = 16'h5105; bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", bus.instr_ready); end
        total++; if ({bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_opext} !== 40'h0 || done !== 1'b0 ||
                     illegal !== 1'b0 || psr !== 5'b0 || dbg_data !== 16'h0) begin
            bad++; $display("FAIL abort_outputs got=%h %h %h %h d%b i%b p%b g%h exp=all zero", bus.alu_a, bus.alu_b,
                            bus.alu_opcode, bus.alu_opext, done, illegal, psr, dbg_data); end
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", dn); end
        read_reg(4'd1, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL abort_r1 got=%h exp=0000", d); end
        model_reset();
    endtask

    task automatic dump_check(input string tag);
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), d);
            total++; if (d !== mr[i]) begin bad++; $display("FAIL %s_r%0d got=%h exp=%h", tag, i, d, mr[i]); end
        end
    endtask

    task automatic test_random();
        logic [3:0] rext [4];
        logic [15:0] ins, ea, eb;
        logic [3:0] eext;
        logic lg, ecin;
        rext = '{4'h1, 4'h5, 4'h6, 4'h7};
        for (int n = 0; n < 48; n++) begin
            case ($urandom_range(0, 7))
                0, 1:    ins = {4'h0, 4'($urandom_range(0, 15)), rext[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
                2:       ins = {4'hA, 4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1) ? 4'h5 : 4'h6,
                                4'($urandom_range(0, 15))};
                3, 4, 5: ins = {4'($urandom_range(5, 7)), 4'($urandom_range(0, 15)), 8'($urandom)};
                default: ins = 16'($urandom);
            endcase
            ref_exec(ins, lg, ea, eb, eext, ecin);
            run_instr(ins);
            total++; if (obs_timeout !== 1'b0 || obs_done_k !== 3 || obs_done_cnt !== 1) begin
                bad++; $display("FAIL rnd_timing ins=%h got=to%b k%0d n%0d exp=to0 k3 n1", ins, obs_timeout,
                                obs_done_k, obs_done_cnt); end
            total++; if (obs_illegal !== !lg) begin bad++; $display("FAIL rnd_illegal ins=%h got=%b exp=%b", ins, obs_illegal, !lg); end
            if (lg) begin
                total++; if (obs_a !== ea || obs_b !== eb || obs_opc !== ins[15:12] || obs_ext !== eext || obs_cin !== ecin) begin
                    bad++; $display("FAIL rnd_operands ins=%h got=%h %h %h %h %b exp=%h %h %h %h %b", ins, obs_a, obs_b,
                                    obs_opc, obs_ext, obs_cin, ea, eb, ins[15:12], eext, ecin); end
            end
            total++; if (psr !== mpsr) begin bad++; $display("FAIL rnd_psr ins=%h got=%b exp=%b", ins, psr, mpsr); end
            if (n % 16 == 15) dump_check("rnd");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [6];
        logic [15:0] ea, eb;
        logic [3:0] eext;
        logic lg, ecin;
        int idx, cyc, last, dones;
        seq = '{16'h5107, 16'h0151, 16'h5280, 16'h0261, 16'hA215, 16'h0471};
        idx = 0; cyc = 0; last = 0; dones = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = seq[0];
        while (idx < 6 && cyc < 60) begin
            if (done) dones++;
            if (bus.instr_ready) begin
                bus.instr = seq[idx];
                if (idx > 0) begin
                    total++; if (cyc - last !== 4) begin bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=4", idx, cyc - last); end
                end
                last = cyc;
                ref_exec(seq[idx], lg, ea, eb, eext, ecin);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.instr_valid = 1'b0;
        total++; if (idx !== 6) begin bad++; $display("FAIL b2b_accepts got=%0d exp=6", idx); end
        repeat (4) begin
            if (done) dones++;
            @(negedge clk);
        end
        total++; if (dones !== 6) begin bad++; $display("FAIL b2b_dones got=%0d exp=6", dones); end
        total++; if (psr !== mpsr) begin bad++; $display("FAIL b2b_psr got=%b exp=%b", psr, mpsr); end
        dump_check("b2b");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1);
    end

    initial begin
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        test_reset();
        test_immediate();
        test_rtype_carry();
        test_illegal();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
